// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory read-port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int unsigned CONFLICT_CNT_W = 16;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_rd_port_arbiter_pick.sv
// Rotating priority picker: first set request searching upward from start, wrapping.
module rr_priority_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W:0]   pos;
  logic [IDX_W-1:0] pos_idx;

  // start is always < NUM_REQ, so a single conditional subtract wraps the sum
  always_comb begin
    grant   = '0;
    idx     = '0;
    found   = 1'b0;
    pos     = '0;
    pos_idx = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      pos = {1'b0, start} + (IDX_W+1)'(off);
      if (pos >= (IDX_W+1)'(NUM_REQ)) begin
        pos = pos - (IDX_W+1)'(NUM_REQ);
      end
      pos_idx = pos[IDX_W-1:0];
      if (!found && req[pos_idx]) begin
        grant[pos_idx] = 1'b1;
        idx            = pos_idx;
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_rd_port_arbiter.sv
// Shares one synchronous memory read port among NUM_REQ requesters, routes read data
// back to the winner after RD_LATENCY cycles and counts schedule conflicts.
module mem_rd_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ARB_MODE   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          req_grant,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_rd_en,
  input  logic [DATA_W-1:0]           mem_rd_data,
  output logic [CONFLICT_CNT_W-1:0]   conflict_cnt,
  output logic                        conflict_sticky
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam arb_mode_e   MODE  = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   start_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_found;
  logic [NUM_REQ-1:0] tag_pipe [RD_LATENCY];
  logic               multi;

  assign start_ptr = (MODE == ARB_RR) ? rr_ptr : '0;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .start (start_ptr),
    .grant (pick_grant),
    .idx   (win_idx),
    .found (pick_found)
  );

  // Grant is one-hot, so OR-ing the gated addresses is the mux and yields 0 when idle
  always_comb begin
    req_grant = rst ? '0 : pick_grant;
    mem_rd_en = pick_found & ~rst;
    mem_addr  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_grant[i]) begin
        mem_addr = mem_addr | req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (mem_rd_en) begin
      rr_ptr <= (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= req_grant;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign rsp_valid = rst ? '0 : tag_pipe[RD_LATENCY-1];
  assign rsp_data  = mem_rd_data;

  // More than one bit set iff clearing the lowest set bit leaves something behind
  assign multi = |(req_valid & (req_valid - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt    <= '0;
      conflict_sticky <= 1'b0;
    end else if (multi) begin
      if (conflict_cnt != '1) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
      conflict_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_rd_port_arbiter.sv
// Bench for mem_rd_port_arbiter: a fixed-priority/latency-1 and a round-robin/latency-3
// instance share stimulus and are checked against a behavioural reference model.
module tb_mem_rd_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [17:0] req_addr = '0;

  logic [2:0]  grant_f, grant_r, rspv_f, rspv_r;
  logic [31:0] rdata_f, rdata_r, mem_f, mem_r;
  logic [5:0]  maddr_f, maddr_r;
  logic        rden_f, rden_r, sticky_f, sticky_r;
  logic [15:0] cnt_f, cnt_r;

  logic [2:0]  obs_grant [2];
  logic [2:0]  obs_rsp   [2];
  logic [31:0] obs_data  [2];
  logic [5:0]  obs_maddr [2];
  logic        obs_rden  [2];
  logic [15:0] obs_cnt   [2];
  logic        obs_sticky[2];

  logic [31:0] mem_words [64];
  logic [5:0]  env_a [2][4];
  logic        env_v [2][4] = '{default: 1'b0};

  int          m_rr [2];
  logic [2:0]  m_tag [2][4];
  logic [5:0]  m_addr [2][4];
  int          m_cnt;
  logic        m_sticky;
  logic [2:0]  e_grant [2];
  logic [2:0]  e_rsp [2];
  logic [5:0]  e_addr [2];
  logic [31:0] e_data [2];
  int          e_win [2];
  logic        cur_rst;
  logic [2:0]  cur_v;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_rd_port_arbiter #(
    .NUM_REQ(3), .ADDR_W(6), .DATA_W(32), .RD_LATENCY(1), .ARB_MODE(0)
  ) u_fix (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_grant(grant_f), .rsp_valid(rspv_f), .rsp_data(rdata_f),
    .mem_addr(maddr_f), .mem_rd_en(rden_f), .mem_rd_data(mem_f),
    .conflict_cnt(cnt_f), .conflict_sticky(sticky_f)
  );

  mem_rd_port_arbiter #(
    .NUM_REQ(3), .ADDR_W(6), .DATA_W(32), .RD_LATENCY(3), .ARB_MODE(1)
  ) u_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_grant(grant_r), .rsp_valid(rspv_r), .rsp_data(rdata_r),
    .mem_addr(maddr_r), .mem_rd_en(rden_r), .mem_rd_data(mem_r),
    .conflict_cnt(cnt_r), .conflict_sticky(sticky_r)
  );

  always_comb begin
    obs_grant[0] = grant_f;  obs_grant[1] = grant_r;
    obs_rsp[0]   = rspv_f;   obs_rsp[1]   = rspv_r;
    obs_data[0]  = rdata_f;  obs_data[1]  = rdata_r;
    obs_maddr[0] = maddr_f;  obs_maddr[1] = maddr_r;
    obs_rden[0]  = rden_f;   obs_rden[1]  = rden_r;
    obs_cnt[0]   = cnt_f;    obs_cnt[1]   = cnt_r;
    obs_sticky[0] = sticky_f; obs_sticky[1] = sticky_r;
  end

  // Synchronous memory environment with per-instance read latency
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int s = 3; s > 0; s--) begin
        env_a[k][s] <= env_a[k][s-1];
        env_v[k][s] <= env_v[k][s-1];
      end
      env_a[k][0] <= obs_maddr[k];
      env_v[k][0] <= obs_rden[k];
    end
  end

  always_comb begin
    mem_f = env_v[0][0] ? mem_words[env_a[0][0]] : 32'hDEAD_BEEF;
    mem_r = env_v[1][2] ? mem_words[env_a[1][2]] : 32'hDEAD_BEEF;
  end

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int pick(input logic [2:0] v, input int start);
    for (int off = 0; off < 3; off++) begin
      if (v[(start + off) % 3]) return (start + off) % 3;
    end
    return -1;
  endfunction

  task automatic apply(input logic r, input logic [2:0] v, input logic [17:0] a);
    int w;
    @(negedge clk);
    rst = r; req_valid = v; req_addr = a;
    cur_rst = r; cur_v = v;
    #1;
    for (int k = 0; k < 2; k++) begin
      w = r ? -1 : pick(v, (k == 1) ? m_rr[k] : 0);
      e_win[k]   = w;
      e_grant[k] = (w < 0) ? 3'b000 : 3'(1 << w);
      e_addr[k]  = (w < 0) ? 6'h00 : a[w*6 +: 6];
      e_rsp[k]   = r ? 3'b000 : m_tag[k][lat(k)-1];
      e_data[k]  = mem_words[m_addr[k][lat(k)-1]];
    end
  endtask

  task automatic commit();
    for (int k = 0; k < 2; k++) begin
      if (cur_rst) begin
        m_rr[k] = 0;
        for (int s = 0; s < 4; s++) begin
          m_tag[k][s] = '0; m_addr[k][s] = '0;
        end
      end else begin
        for (int s = 3; s > 0; s--) begin
          m_tag[k][s] = m_tag[k][s-1]; m_addr[k][s] = m_addr[k][s-1];
        end
        m_tag[k][0] = e_grant[k];
        m_addr[k][0] = e_addr[k];
        if (e_win[k] >= 0) m_rr[k] = (e_win[k] + 1) % 3;
      end
    end
    if (cur_rst) begin
      m_cnt = 0; m_sticky = 1'b0;
    end else if ($countones(cur_v) > 1) begin
      if (m_cnt < 65535) m_cnt++;
      m_sticky = 1'b1;
    end
  endtask

  task automatic do_reset();
    apply(1'b1, 3'b000, '0); commit();
    apply(1'b1, 3'b000, '0); commit();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, 3'b111, 18'($urandom));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_grant[k] !== 3'b000 || obs_rden[k] !== 1'b0) begin
          failures++;
          $display("FAIL reset_grant[%0d]: got grant=%b rd_en=%b expected 000/0", k, obs_grant[k], obs_rden[k]);
        end
        checks++;
        if (obs_rsp[k] !== 3'b000 || obs_maddr[k] !== 6'h00) begin
          failures++;
          $display("FAIL reset_rsp[%0d]: got rsp=%b addr=%h expected 000/00", k, obs_rsp[k], obs_maddr[k]);
        end
        if (c > 0) begin
          checks++;
          if (obs_cnt[k] !== 16'h0000 || obs_sticky[k] !== 1'b0) begin
            failures++;
            $display("FAIL reset_cnt[%0d]: got cnt=%h sticky=%b expected 0000/0", k, obs_cnt[k], obs_sticky[k]);
          end
        end
      end
      commit();
    end
  endtask

  task automatic test_single();
    logic [17:0] a;
    a = 18'($urandom);
    a[11:6] = 6'h15;
    apply(1'b0, 3'b010, a);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_grant[k] !== 3'b010 || obs_maddr[k] !== 6'h15 || obs_rden[k] !== 1'b1) begin
        failures++;
        $display("FAIL single_issue[%0d]: got grant=%b addr=%h en=%b expected 010/15/1", k, obs_grant[k], obs_maddr[k], obs_rden[k]);
      end
    end
    commit();
    for (int c = 1; c <= 3; c++) begin
      apply(1'b0, 3'b000, 18'($urandom));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_rsp[k] !== ((c == lat(k)) ? 3'b010 : 3'b000)) begin
          failures++;
          $display("FAIL single_rsp[%0d] c%0d: got %b expected %b", k, c, obs_rsp[k], (c == lat(k)) ? 3'b010 : 3'b000);
        end
        if (c == lat(k)) begin
          checks++;
          if (obs_data[k] !== mem_words[6'h15]) begin
            failures++;
            $display("FAIL single_data[%0d]: got %h expected %h", k, obs_data[k], mem_words[6'h15]);
          end
        end
      end
      commit();
    end
  endtask

  task automatic test_staggered();
    logic [17:0] a;
    logic [5:0]  sa [3];
    logic [2:0]  v;
    logic [2:0]  er;
    int          j;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      a = 18'($urandom);
      v = (c < 3) ? 3'(1 << c) : 3'b000;
      if (c < 3) sa[c] = a[c*6 +: 6];
      apply(1'b0, v, a);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_grant[k] !== v) begin
          failures++;
          $display("FAIL stagger_grant[%0d] c%0d: got %b expected %b", k, c, obs_grant[k], v);
        end
        j = c - lat(k);
        er = (j >= 0 && j < 3) ? 3'(1 << j) : 3'b000;
        checks++;
        if (obs_rsp[k] !== er) begin
          failures++;
          $display("FAIL stagger_rsp[%0d] c%0d: got %b expected %b", k, c, obs_rsp[k], er);
        end
        if (j >= 0 && j < 3) begin
          checks++;
          if (obs_data[k] !== mem_words[sa[j]]) begin
            failures++;
            $display("FAIL stagger_data[%0d] c%0d: got %h expected %h", k, c, obs_data[k], mem_words[sa[j]]);
          end
        end
        checks++;
        if (obs_cnt[k] !== 16'h0000 || obs_sticky[k] !== 1'b0) begin
          failures++;
          $display("FAIL stagger_cnt[%0d] c%0d: got cnt=%h sticky=%b expected 0000/0", k, c, obs_cnt[k], obs_sticky[k]);
        end
      end
      commit();
    end
  endtask

  task automatic test_fixed_conflict();
    logic [17:0] a;
    do_reset();
    a = 18'($urandom);
    apply(1'b0, 3'b111, a);
    checks++;
    if (obs_grant[0] !== 3'b001 || obs_maddr[0] !== a[5:0]) begin
      failures++;
      $display("FAIL fixed_conflict_grant: got grant=%b addr=%h expected 001/%h", obs_grant[0], obs_maddr[0], a[5:0]);
    end
    commit();
    apply(1'b0, 3'b000, 18'($urandom));
    checks++;
    if (obs_rsp[0] !== 3'b001) begin
      failures++;
      $display("FAIL fixed_conflict_rsp: got %b expected 001", obs_rsp[0]);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_cnt[k] !== 16'd1 || obs_sticky[k] !== 1'b1) begin
        failures++;
        $display("FAIL fixed_conflict_cnt[%0d]: got cnt=%h sticky=%b expected 0001/1", k, obs_cnt[k], obs_sticky[k]);
      end
    end
    commit();
  endtask

  task automatic test_rr_rotation();
    logic [2:0] exp_g;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 3'b111, 18'($urandom));
      exp_g = 3'(1 << (i % 3));
      checks++;
      if (obs_grant[1] !== exp_g || obs_grant[0] !== 3'b001) begin
        failures++;
        $display("FAIL rr_rotation i%0d: got rr=%b fixed=%b expected %b/001", i, obs_grant[1], obs_grant[0], exp_g);
      end
      commit();
    end
    apply(1'b0, 3'b000, '0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs_cnt[k] !== 16'd6) begin
        failures++;
        $display("FAIL rr_rotation_cnt[%0d]: got %0d expected 6", k, obs_cnt[k]);
      end
    end
    commit();
  endtask

  task automatic test_random();
    logic [2:0] v;
    logic       r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(39) == 0);
      v = ($urandom_range(1) == 0) ? 3'($urandom) : 3'(1 << $urandom_range(3));
      apply(r, v, 18'($urandom));
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_grant[k] !== e_grant[k] || obs_rden[k] !== (e_grant[k] != 3'b000)) begin
          failures++;
          $display("FAIL random_grant[%0d] i%0d: got %b/%b expected %b", k, i, obs_grant[k], obs_rden[k], e_grant[k]);
        end
        checks++;
        if (obs_maddr[k] !== e_addr[k]) begin
          failures++;
          $display("FAIL random_addr[%0d] i%0d: got %h expected %h", k, i, obs_maddr[k], e_addr[k]);
        end
        checks++;
        if (obs_rsp[k] !== e_rsp[k]) begin
          failures++;
          $display("FAIL random_rsp[%0d] i%0d: got %b expected %b", k, i, obs_rsp[k], e_rsp[k]);
        end
        if (e_rsp[k] != 3'b000) begin
          checks++;
          if (obs_data[k] !== e_data[k]) begin
            failures++;
            $display("FAIL random_data[%0d] i%0d: got %h expected %h", k, i, obs_data[k], e_data[k]);
          end
        end
        checks++;
        if (obs_cnt[k] !== 16'(m_cnt) || obs_sticky[k] !== m_sticky) begin
          failures++;
          $display("FAIL random_cnt[%0d] i%0d: got %0d/%b expected %0d/%b", k, i, obs_cnt[k], obs_sticky[k], m_cnt, m_sticky);
        end
      end
      commit();
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    apply(1'b0, 3'b001, 18'($urandom));
    checks++;
    if (obs_grant[1] !== 3'b001) begin
      failures++;
      $display("FAIL midflight_grant: got %b expected 001", obs_grant[1]);
    end
    commit();
    apply(1'b1, 3'b000, '0);
    commit();
    for (int c = 2; c <= 4; c++) begin
      apply(1'b0, 3'b000, '0);
      checks++;
      if (obs_rsp[1] !== 3'b000 || obs_cnt[1] !== 16'h0000 || obs_sticky[1] !== 1'b0) begin
        failures++;
        $display("FAIL midflight_rsp c%0d: got rsp=%b cnt=%h sticky=%b expected 000/0000/0", c, obs_rsp[1], obs_cnt[1], obs_sticky[1]);
      end
      commit();
    end
    apply(1'b0, 3'b111, 18'($urandom));
    checks++;
    if (obs_grant[1] !== 3'b001) begin
      failures++;
      $display("FAIL midflight_rr_ptr: got %b expected 001", obs_grant[1]);
    end
    commit();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 70000; i++) begin
      apply(1'b0, 3'b111, '0);
      commit();
    end
    for (int c = 0; c < 2; c++) begin
      apply(1'b0, 3'b110, '0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs_cnt[k] !== 16'hFFFF || obs_sticky[k] !== 1'b1) begin
          failures++;
          $display("FAIL saturation[%0d] c%0d: got %h/%b expected ffff/1", k, c, obs_cnt[k], obs_sticky[k]);
        end
      end
      commit();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_words[i] = $urandom;
    for (int k = 0; k < 2; k++) begin
      m_rr[k] = 0;
      for (int s = 0; s < 4; s++) begin
        m_tag[k][s] = '0; m_addr[k][s] = '0;
      end
    end
    m_cnt = 0;
    m_sticky = 1'b0;
    test_reset();
    test_single();
    test_staggered();
    test_fixed_conflict();
    test_rr_rotation();
    test_random();
    test_reset_midflight();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
